// File: rtl/mips_lsu_if.sv
// mips_lsu_if: request/response and memory-bus bundle for the load/store unit.
// Modports: master = datapath requester, slave = LSU, memory = wait-request memory.
interface mips_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_err;
  logic                  stall;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic [DATA_W-1:0]     mem_writedata;
  logic [DATA_W-1:0]     mem_readdata;
  logic                  mem_waitrequest;

  modport master (
    output req_valid, req_store, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data,
    input  resp_err, stall
  );

  modport slave (
    input  req_valid, req_store, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data,
    output resp_err, stall,
    output mem_address, mem_read, mem_write,
    output mem_byteenable, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport memory (
    input  mem_address, mem_read, mem_write,
    input  mem_byteenable, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/mips_lsu.sv
// mips_lsu: multicycle load/store unit between the MIPS datapath and a
// wait-request memory bus. Ports: clk, reset (async, active-low), bus (slave).
module mips_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mips_lsu_if.slave bus
);

  localparam int B  = DATA_W / 8;
  localparam int OW = $clog2(B);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OW-1:0]     off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [B-1:0]      be_q, be_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [OW-1:0]     req_off;
  logic              req_legal;
  logic [B-1:0]      req_be;
  logic [DATA_W-1:0] req_steer;
  logic [DATA_W-1:0] load_ext;
  logic              in_access;

  assign req_off   = bus.req_addr[OW-1:0];
  assign in_access = (state_q == S_ACCESS);

  // Request decode: legality, byte lanes and store-data replication.
  always_comb begin : req_dec
    int n;
    n         = 1 << bus.req_size;
    req_legal = (int'(bus.req_size) <= OW)
             && ((int'(req_off) & (n - 1)) == 0);
    req_be    = '0;
    req_steer = '0;
    for (int i = 0; i < B; i++) begin
      req_be[i] = (i >= int'(req_off))
               && (i < int'(req_off) + n);
      // each n-byte slot carries the same data, so the
      // addressed lane is right whatever the offset
      req_steer[8*i +: 8] = bus.req_wdata[8*(i & (n-1)) +: 8];
    end
  end

  // Load data: select bytes [off, off+n) and extend.
  always_comb begin : ld_ext
    logic [DATA_W-1:0] shifted;
    logic              sign;
    int                n;
    shifted  = bus.mem_readdata >> {off_q, 3'b000};
    n        = 1 << size_q;
    sign     = 1'b0;
    load_ext = '0;
    for (int i = 0; i < B; i++) begin
      if (i == n - 1) sign = sgn_q & shifted[8*i + 7];
    end
    for (int i = 0; i < B; i++) begin
      load_ext[8*i +: 8] = (i < n) ? shifted[8*i +: 8]
                                   : {8{sign}};
    end
  end

  always_comb begin : nxt
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          off_d   = req_off;
          addr_d  = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
          wdata_d = req_steer;
          be_d    = req_be;
          if (req_legal) begin
            state_d = S_ACCESS;
            err_d   = 1'b0;
          end else begin
            // illegal requests never touch the bus
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_ACCESS: begin
        if (!bus.mem_waitrequest) begin
          state_d = S_RESP;
          rdata_d = store_q ? '0 : load_ext;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.stall          = (state_q != S_IDLE);
  assign bus.resp_valid     = (state_q == S_RESP);
  assign bus.resp_err       = (state_q == S_RESP) & err_q;
  assign bus.resp_data      = rdata_q;
  assign bus.mem_read       = in_access & ~store_q;
  assign bus.mem_write      = in_access & store_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = in_access ? be_q : '0;
  assign bus.mem_writedata  = wdata_q;

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Parametrised multicycle load/store unit that sits between the MIPS datapath and a wait-request style memory bus.
- Replaces inline memory-extension muxing with a handshaked unit supporting byte, half, word and, when DATA_W permits, double accesses.
- Performs lane steering, byte-enable generation, sign/zero extension and misalignment detection.
- Stalls the control FSM while an access is in flight.

## Interface
Parameters:
- DATA_W, 32, bus/register width in bits; multiple of 8, power of two, ≥32.
- ADDR_W, 32, byte-address width.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 byte, 1 half, 2 word, 3 double (legal only if DATA_W = 64 or more).
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size; valid with resp_valid.
- stall  out  1  high whenever state is not IDLE.
- mem_address  out  ADDR_W  bus-word-aligned address; low log2(DATA_W/8) bits are 0.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  DATA_W/8  active byte lanes.
- mem_writedata  out  DATA_W  lane-steered store data.
- mem_readdata  in  DATA_W  read data; sampled only when waitrequest is low.
- mem_waitrequest  in  1  memory not ready; hold request.

## Operation
Definitions: B = DATA_W/8; off = req_addr[log2(B)-1:0]; n = 1<<req_size.

States and transitions:
- IDLE → ACCESS on req_valid with a legal request.
- IDLE → RESP on req_valid with an illegal request; no bus activity, resp_err=1.
- ACCESS → RESP when mem_waitrequest=0.
- RESP → IDLE unconditionally.

Legality:
- Illegal if n > B.
- Illegal if off is not a multiple of n (misaligned).

Capture at accept (req_valid & req_ready): register store flag, size, signed, off, address, and steered write data.

Bus signals:
- mem_read/mem_write are driven only in ACCESS, decoded from registered state.
- mem_byteenable = ((1<<n)-1) << off, truncated to B bits.
- mem_writedata = req_wdata low n bytes replicated across all B/n slots, so the addressed lane is correct.

Load data:
- On completion, take bytes [off, off+n) of mem_readdata and right-align them.
- req_signed=1: fill upper bits with bit 8n-1. Otherwise fill with zeros.
- n = B: data is passed through unchanged.

Response and ignored inputs:
- RESP drives resp_valid=1 for exactly one cycle; resp_data is held until the next completion.
- req_valid while not ready is ignored; the requester must hold the request until it is accepted.

## Timing
- Reset (asynchronous, immediate on falling edge):
  - state = IDLE, so req_ready=1 and stall=0.
  - resp_valid=0, resp_data=0, resp_err=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0.
- Reset mid-ACCESS: strobes drop asynchronously and no response is issued. The memory side must tolerate an abandoned transfer.
- Latency, legal access with W waitrequest cycles: accept at cycle 0; ACCESS cycles 1..1+W; resp_valid at cycle 2+W. Minimum 3 cycles from accept to the next accept.
- Latency, illegal access: resp_valid at cycle 1; next accept at cycle 2.
- While mem_waitrequest=1: mem_address, byteenable, writedata and strobes are held stable.
- stall = (state != IDLE). It is asserted combinationally from registered state, so the datapath freezes from the cycle after accept.
- No back-to-back accepts. req_ready is low in ACCESS and RESP.

## Test plan
- DATA_W=32, load byte signed at 0x1003; readdata 0x80_00_00_00, waitrequest=0 → byteenable 0b1000, address 0x1000, resp_data 0xFFFFFF80 at cycle 2.
- Load half unsigned at 0x2002; readdata 0xBEEF_1234, waitrequest high 3 cycles → resp_data 0x0000BEEF at cycle 5; address and strobe stable throughout.
- Store half at 0x3002, wdata 0x0000ABCD → mem_writedata 0xABCDABCD, byteenable 0b1100, mem_write for 1 cycle; resp_data 0.
- Load word at 0x4001 → no mem_read; resp_err=1 and resp_valid at cycle 1. Also req_size=3 with DATA_W=32 → resp_err=1.
- DATA_W=64, load double at 0x8 → byteenable 0xFF, data passed through. Signed word at 0xC, readdata[63:32]=0x8000_0001 → resp_data 0xFFFFFFFF80000001.
- Assert reset low during ACCESS with waitrequest=1 → mem_read falls in the same cycle, no resp_valid, req_ready=1 after release.
